// File: rtl/serial_fa_pkg.sv
// Shared definitions for the bit-serial adder/subtractor engine.
// State encoding, op encoding, fa_cell function selects and the majority helper.
package serial_fa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic SEL_SUM   = 1'b0;
   localparam logic SEL_CARRY = 1'b1;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full-adder slice.
// sel chooses the output: the sum bit (parity) or the carry (majority).
module fa_cell
   import serial_fa_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic sel,
   output logic out
);

   assign out = (sel == SEL_CARRY) ? maj3(a, b, c) : (a ^ b ^ c);

endmodule

// File: rtl/serial_fa_engine.sv
// Bit-serial add/subtract engine: one bit per clock, LSB first, with
// valid/ready handshakes on both sides and registered flags.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | in_ready high; waits for an operand set
// RUN     | processes one bit per cycle for WIDTH cycles
// DONE    | result held with out_valid high until out_ready
module serial_fa_engine
   import serial_fa_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic             s_bit;
   logic             c_next;
   logic             accept;
   logic             last_bit;
   logic             handoff;

   fa_cell u_sum_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .c   (carry_q),
      .sel (SEL_SUM),
      .out (s_bit)
   );

   fa_cell u_carry_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .c   (carry_q),
      .sel (SEL_CARRY),
      .out (c_next)
   );

   assign accept   = in_valid && (state_q == ST_IDLE);
   assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_BIT);
   assign handoff  = (state_q == ST_DONE) && out_ready;
   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign res_next = {s_bit, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_bit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (handoff) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else if (accept) begin
         a_sh    <= a;
         // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
         b_sh    <= (op == OP_SUB) ? ~b : b;
         carry_q <= (op == OP_SUB) ? 1'b1 : cin;
         cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         res_sh  <= res_next;
         carry_q <= c_next;
         cnt_q   <= cnt_q + CW'(1);
      end
   end

   // Visible result registers only change on entry to DONE, so they stay
   // steady while the next operation shifts through the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (last_bit) begin
         sum_q  <= res_next;
         cout_q <= c_next;
         ovf_q  <= carry_q ^ c_next;
         zero_q <= (res_next == '0);
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_fa_engine.sv
// Self-checking bench for serial_fa_engine (WIDTH = 8): directed corner cases,
// randomized operations against an arithmetic reference model, stall, back-to-back and reset.
module tb_serial_fa_engine;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int n_cmp;
   int n_bad;

   serial_fa_engine #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, output logic [W-1:0] s, output logic co,
                                 output logic ov, output logic z);
      longint ux, uy, ur, sx, sy, sr;
      ux = longint'(x);
      uy = longint'(y);
      sx = (x[W-1]) ? ux - (longint'(1) << W) : ux;
      sy = (y[W-1]) ? uy - (longint'(1) << W) : uy;
      if (o) begin
         ur = ux - uy;
         sr = sx - sy;
         co = (ux >= uy);
      end else begin
         ur = ux + uy + longint'(ci);
         sr = sx + sy + longint'(ci);
         co = (ur >= (longint'(1) << W));
      end
      s  = W'(ur);
      ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
      z  = (s == '0);
   endfunction

   // Offers one operand set (called #1 after a rising edge, engine in IDLE),
   // scrambles inputs while busy, and returns outputs at the first out_valid cycle.
   task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, output int lat, output logic [W-1:0] s,
                        output logic co, output logic ov, output logic z);
      op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid && lat < 4*W) begin
         a = W'($urandom); b = W'($urandom); op = 1'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      s = sum; co = cout; ov = ovf; z = zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, out_valid, sum, cout, ovf, zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b sum=%h c=%b v=%b z=%b, need rdy=1 vld=0 sum=00 c=0 v=0 z=0",
                  in_ready, out_valid, sum, cout, ovf, zero);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic         t_op [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] t_a  [4] = '{8'h7F, 8'hFF, 8'h05, 8'h80};
      logic [W-1:0] t_b  [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
      logic         t_ci [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [W+2:0] t_ex [4] = '{{8'h80, 3'b010}, {8'h00, 3'b101}, {8'hFE, 3'b000}, {8'h7F, 3'b110}};
      int lat;
      logic [W-1:0] s;
      logic co, ov, z;
      for (int i = 0; i < 4; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], t_ci[i], lat, s, co, ov, z);
         n_cmp++;
         if (lat !== W) begin
            n_bad++;
            $display("FAIL directed_latency[%0d]: got %0d cycles, need %0d", i, lat, W);
         end
         n_cmp++;
         if ({s, co, ov, z} !== t_ex[i]) begin
            n_bad++;
            $display("FAIL directed_result[%0d]: got sum=%h c=%b v=%b z=%b, need sum=%h c=%b v=%b z=%b",
                     i, s, co, ov, z, t_ex[i][W+2:3], t_ex[i][2], t_ex[i][1], t_ex[i][0]);
         end
         @(posedge clk); #1;
         n_cmp++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL directed_handoff[%0d]: got vld=%b rdy=%b, need vld=0 rdy=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_stall();
      int lat;
      logic [W-1:0] s, es;
      logic co, ov, z, eco, eov, ez;
      out_ready = 1'b0;
      model(1'b0, 8'h3C, 8'h4A, 1'b1, es, eco, eov, ez);
      do_op(1'b0, 8'h3C, 8'h4A, 1'b1, lat, s, co, ov, z);
      n_cmp++;
      if ({s, co, ov, z} !== {es, eco, eov, ez}) begin
         n_bad++;
         $display("FAIL stall_result: got sum=%h c=%b v=%b z=%b, need sum=%h c=%b v=%b z=%b",
                  s, co, ov, z, es, eco, eov, ez);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         n_cmp++;
         if ({out_valid, in_ready, sum, cout, ovf, zero} !== {1'b1, 1'b0, es, eco, eov, ez}) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b sum=%h c=%b v=%b z=%b, need vld=1 rdy=0 sum=%h c=%b v=%b z=%b",
                     i, out_valid, in_ready, sum, cout, ovf, zero, es, eco, eov, ez);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL stall_release: got vld=%b rdy=%b, need vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [W-1:0] x, y, s, es;
      logic o, ci, co, ov, z, eco, eov, ez;
      for (int i = 0; i < 20; i++) begin
         x = W'($urandom); y = W'($urandom); o = 1'($urandom); ci = 1'($urandom);
         model(o, x, y, ci, es, eco, eov, ez);
         do_op(o, x, y, ci, lat, s, co, ov, z);
         n_cmp++;
         if (lat !== W || {s, co, ov, z} !== {es, eco, eov, ez}) begin
            n_bad++;
            $display("FAIL random[%0d] op=%b a=%h b=%h cin=%b: got lat=%0d sum=%h c=%b v=%b z=%b, need lat=%0d sum=%h c=%b v=%b z=%b",
                     i, o, x, y, ci, lat, s, co, ov, z, W, es, eco, eov, ez);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [W+2:0] exp_q[$];
      logic [W+2:0] e;
      logic [W-1:0] es;
      logic eco, eov, ez;
      int k, last_acc, accepted, done;
      k = 0; last_acc = -1; accepted = 0; done = 0;
      out_ready = 1'b1;
      while (done < 6 && k < 200) begin
         if (out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL b2b_extra: got unexpected result sum=%h, need none", sum);
            end else begin
               e = exp_q.pop_front();
               if ({sum, cout, ovf, zero} !== e) begin
                  n_bad++;
                  $display("FAIL b2b_result[%0d]: got sum=%h c=%b v=%b z=%b, need sum=%h c=%b v=%b z=%b",
                           done, sum, cout, ovf, zero, e[W+2:3], e[2], e[1], e[0]);
               end
            end
            done++;
         end
         if (in_ready && accepted < 6) begin
            a = W'($urandom); b = W'($urandom); op = 1'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            model(op, a, b, cin, es, eco, eov, ez);
            exp_q.push_back({es, eco, eov, ez});
            if (last_acc >= 0) begin
               n_cmp++;
               if (k - last_acc !== W + 2) begin
                  n_bad++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles, need %0d", accepted, k - last_acc, W + 2);
               end
            end
            last_acc = k;
            accepted++;
         end else if (accepted >= 6) begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (done !== 6) begin
         n_bad++;
         $display("FAIL b2b_timeout: got %0d results, need 6", done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun();
      int lat, seen;
      logic [W-1:0] s;
      logic co, ov, z;
      op = 1'b0; a = 8'h55; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, in_ready, sum, cout, ovf, zero} !== {1'b0, 1'b1, {W{1'b0}}, 3'b000}) begin
         n_bad++;
         $display("FAIL midrun_reset: got vld=%b rdy=%b sum=%h c=%b v=%b z=%b, need vld=0 rdy=1 sum=00 c=0 v=0 z=0",
                  out_valid, in_ready, sum, cout, ovf, zero);
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 2*W; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL midrun_ghost: got %0d out_valid cycles after release, need 0", seen);
      end
      do_op(1'b0, 8'h01, 8'h01, 1'b0, lat, s, co, ov, z);
      n_cmp++;
      if (lat !== W || {s, co, ov, z} !== {8'h02, 3'b000}) begin
         n_bad++;
         $display("FAIL midrun_recover: got lat=%0d sum=%h c=%b v=%b z=%b, need lat=%0d sum=02 c=0 v=0 z=0",
                  lat, s, co, ov, z, W);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_directed();
      test_stall();
      test_random();
      test_back_to_back();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_fa_engine.md
SERIAL_FA_ENGINE -- requirements
Module: serial_fa_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand set offered.
REQ-005 SHALL have port in_ready, output, 1, engine accepts operands.
REQ-006 SHALL have port op, input, 1, 0 = add, 1 = subtract (a - b).
REQ-007 SHALL have port a, input, WIDTH, first operand.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port cin, input, 1, carry-in; ignored when op = 1.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port sum, output, WIDTH, result bits.
REQ-013 SHALL have port cout, output, 1, carry-out; for subtract, 1 = no borrow.
REQ-014 SHALL have port ovf, output, 1, signed two's-complement overflow.
REQ-015 SHALL have port zero, output, 1, sum equals 0.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL, on in_valid & in_ready, latch a, b (b inverted when op = 1), and carry register = (op ? 1 : cin), clear bit counter, and go to RUN.
REQ-019 SHALL, per RUN cycle, process one bit LSB-first: sum bit = a_i ^ b_i ^ c, carry register <= maj(a_i, b_i, c), shift operand and result registers.
REQ-020 SHALL leave RUN after exactly WIDTH cycles, entering DONE; out_valid rises WIDTH cycles after the accept edge.
REQ-021 SHALL compute ovf = carry into MSB XOR carry out of MSB, and zero = (sum == 0), both registered on entry to DONE.
REQ-022 SHALL hold out_valid and sum, cout, ovf, zero stable in DONE until out_valid & out_ready, then return to IDLE.
REQ-023 SHALL NOT accept a new operand set in the same cycle as result handoff; back-to-back throughput is one result per WIDTH + 2 cycles with out_ready held high.
REQ-024 SHALL ignore in_valid, op, a, b and cin outside IDLE.
REQ-025 SHALL keep sum, cout, ovf and zero at their last values outside DONE; consumers qualify them with out_valid.

Reset
REQ-026 SHALL, on rst_n low, immediately force IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0, counter and carry register = 0.
REQ-027 SHALL abandon any in-flight RUN or DONE operation on reset, with no result emitted after release.

Structure
REQ-028 SHALL take the state enum and op encoding constants from shared package serial_fa_pkg.
REQ-029 SHALL instantiate sub-module fa_cell (inputs a, b, c, sel; out = sel ? maj(a, b, c) : a ^ b ^ c) twice, sel = 0 for sum and sel = 1 for carry.

Verification (WIDTH = 8)
REQ-030 SHALL cover add 0x7F + 0x01, cin = 0 -> sum 0x80, cout 0, ovf 1, zero 0, out_valid 8 cycles after accept.
REQ-031 SHALL cover add 0xFF + 0x01, cin = 0 -> sum 0x00, cout 1, ovf 0, zero 1.
REQ-032 SHALL cover sub 0x05 - 0x07 -> sum 0xFE, cout 0, ovf 0; and sub 0x80 - 0x01 -> sum 0x7F, cout 1, ovf 1.
REQ-033 SHALL cover out_ready held low 5 cycles in DONE -> outputs stable and in_ready 0 throughout; handoff on the first high cycle, IDLE on the next.
REQ-034 SHALL cover rst_n asserted at RUN bit 4 -> out_valid 0 and in_ready 1 immediately; a new 0x01 + 0x01 accepted after release -> sum 0x02.
